maze_walker: RTL and testbench
==============================

Name: maze_walker

Overview:
- Parametrised successor to the 64x64 maze solver: wall-follower that walks a square maze stored in external single-bit memory, marking visited cells, until it reaches the border.
- Adds start handshake, selectable right-/left-hand rule, parametrised maze size, step counter, step-limit timeout and enclosed-start detection with a fail flag.
- Sits between the top-level controller and the maze memory; drives row/col/maze_oe/maze_we directly.

Parameters:
ADDR_W, 6, row/col width; maze is 2**ADDR_W x 2**ADDR_W, MAXC = 2**ADDR_W-1
HAND, 0, 0 = right-hand rule, 1 = left-hand rule
STEP_W, 16, width of step counter
MAX_STEPS, 16'hFFFF, move count at which the walk aborts with fail (must be < 2**STEP_W)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin walk; sampled only in IDLE/DONE/FAIL
starting_row  in  ADDR_W  start row, sampled with start
starting_col  in  ADDR_W  start col, sampled with start
maze_in  in  1  cell content for address presented the previous cycle with maze_oe: 1 = wall, 0 = free
row  out  ADDR_W  memory row address (registered)
col  out  ADDR_W  memory col address (registered)
maze_oe  out  1  read enable, one-cycle pulse per probe
maze_we  out  1  write enable, marks cell at row/col visited
busy  out  1  walk in progress
done  out  1  border reached; sticky until next start or reset
fail  out  1  enclosed start or MAX_STEPS hit; sticky until next start or reset
step_count  out  STEP_W  moves made in current/last walk

Behaviour:
- Reset (async, rst_n=0): state IDLE, row=col=0, maze_oe=maze_we=0, busy=done=fail=0, step_count=0, heading=EAST, try=0. All outputs registered.
- Heading encoding: 0 EAST (col+1), 1 NORTH (row-1), 2 WEST (col-1), 3 SOUTH (row+1).
- Probe order per position, try index 0..3: HAND=0 -> right of heading, straight, left, back; HAND=1 -> left, straight, right, back.
- States:
  - IDLE/DONE/FAIL: on start: latch start coords, clear done/fail/step_count, heading=EAST, busy=1, go INIT. start ignored in all other states.
  - INIT: row/col=start, maze_we=1 for one cycle. If start on border (row or col equal to 0 or MAXC) -> DONE, step_count=0. Else -> PROBE.
  - PROBE: row/col=candidate(pos, heading, try), maze_oe=1 -> EVAL.
  - EVAL: maze_in valid. Wall: if try==3 -> FAIL, else try+1 -> PROBE. Free -> MOVE.
  - MOVE: pos=candidate, heading=candidate direction, try=0, step_count+1, maze_we=1 at new row/col. Then: new cell on border -> DONE; else new step_count==MAX_STEPS -> FAIL; else PROBE.
  - DONE: done=1, busy=0. FAIL: fail=1, busy=0. row/col hold last values.
- Timing: 1 cycle INIT, 2 cycles per probe, 1 cycle per move. Start to done for a 4-move straight corridor with the right-side wall probed first: 1 + 4*(2+2+1) = 21 cycles after the start-sampling edge.
- Border check on every moved-to cell guarantees candidates never wrap; no modular arithmetic is required beyond ADDR_W.
- Visited marks (maze_we) are write-only; the walker does not treat visited cells as walls.
- done and fail are never both 1. Border and MAX_STEPS reached on the same move -> DONE wins.
- rst_n asserted mid-walk -> immediate return to reset values; any in-flight maze_we is dropped.

Decomposition:
- maze_pkg: dir_t (EAST/NORTH/WEST/SOUTH), state_t (IDLE, INIT, PROBE, EVAL, MOVE, DONE, FAIL), HAND_RIGHT/HAND_LEFT constants, function turn(dir, try, hand) returning probe direction.
- Sub-module maze_probe_gen: combinational; takes pos, heading, try and HAND, and outputs candidate row/col and candidate dir. The FSM and counters stay in maze_walker.

Test Plan:
- ADDR_W=3, corridor row 3 cols 3..7 free, all else wall, start (3,3), HAND=0 -> done=1 after 21 cycles, step_count=4, final row=3 col=7, 5 maze_we pulses.
- Start (0,5) -> maze_we at (0,5), done=1 the cycle after INIT, step_count=0, no maze_oe pulse.
- Start (4,4) with all 4 neighbours walls -> 4 maze_oe pulses, fail=1, done=0, step_count=0.
- Loop maze (ring of free cells, no exit), MAX_STEPS=10 -> fail=1 exactly when step_count=10.
- Same asymmetric dead-end maze, HAND=0 vs HAND=1 -> different exit coords matching golden model, e.g. (0,2) vs (7,2).
- rst_n low for 1 cycle mid-walk, then start with new coords -> outputs at reset values, then a clean walk with step_count from 0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and the probe-order rule for the wall-following maze walker.
// Headings rotate counter-clockwise: EAST, NORTH, WEST, SOUTH.
package maze_pkg;

  typedef enum logic [1:0] {
    EAST  = 2'd0,
    NORTH = 2'd1,
    WEST  = 2'd2,
    SOUTH = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PROBE,
    EVAL,
    MOVE,
    DONE,
    FAIL
  } state_t;

  localparam bit HAND_RIGHT = 1'b0;
  localparam bit HAND_LEFT  = 1'b1;

  // Right hand probes right(+3), straight, left(+1), back(+2); left hand swaps the sides.
  function automatic dir_t turn(dir_t dir, logic [1:0] try_idx, bit hand);
    logic [1:0] offset;
    logic [1:0] raw;
    offset = hand ? (try_idx ^ 2'd1) : (try_idx + 2'd3);
    raw    = dir + offset;
    return dir_t'(raw);
  endfunction

endpackage

// File: rtl/maze_probe_gen.sv
// Combinational neighbour generator: direction and address of the cell to probe
// for a given position, heading and try index.
module maze_probe_gen
  import maze_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter bit HAND   = HAND_RIGHT
) (
  input  logic [ADDR_W-1:0] pos_row,
  input  logic [ADDR_W-1:0] pos_col,
  input  dir_t              heading,
  input  logic [1:0]        try_idx,
  output logic [ADDR_W-1:0] cand_row,
  output logic [ADDR_W-1:0] cand_col,
  output dir_t              cand_dir
);

  dir_t dir;

  // No wrap handling: the walker stops on the border before any neighbour could wrap.
  always_comb begin
    dir      = turn(heading, try_idx, HAND);
    cand_dir = dir;
    cand_row = pos_row;
    cand_col = pos_col;
    unique case (dir)
      EAST:    cand_col = pos_col + ADDR_W'(1);
      NORTH:   cand_row = pos_row - ADDR_W'(1);
      WEST:    cand_col = pos_col - ADDR_W'(1);
      SOUTH:   cand_row = pos_row + ADDR_W'(1);
      default: cand_dir = dir;
    endcase
  end

endmodule

// File: rtl/maze_walker.sv
// Wall-following maze walker: probes neighbours in hand-rule order through a
// single-bit maze memory, marks visited cells and stops on the border.
module maze_walker
  import maze_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter bit                HAND      = HAND_RIGHT,
  parameter int                STEP_W    = 16,
  parameter logic [STEP_W-1:0] MAX_STEPS = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] starting_row,
  input  logic [ADDR_W-1:0] starting_col,
  input  logic              maze_in,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              maze_oe,
  output logic              maze_we,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [STEP_W-1:0] step_count
);

  localparam logic [ADDR_W-1:0] MAXC = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pos_row, pos_col, pos_row_nxt, pos_col_nxt;
  dir_t              heading, heading_nxt;
  dir_t              cand_dir_q, cand_dir_q_nxt;
  logic [1:0]        try_idx, try_nxt;
  logic [ADDR_W-1:0] cand_row, cand_col;
  dir_t              cand_dir;
  logic [ADDR_W-1:0] row_nxt, col_nxt;
  logic              oe_nxt, we_nxt, busy_nxt, done_nxt, fail_nxt;
  logic [STEP_W-1:0] step_nxt, step_inc;

  function automatic logic on_border(logic [ADDR_W-1:0] r, logic [ADDR_W-1:0] c);
    return (r == '0) || (r == MAXC) || (c == '0) || (c == MAXC);
  endfunction

  // Fed with next-cycle position/heading/try so the probe address is registered on entry to PROBE.
  maze_probe_gen #(
    .ADDR_W (ADDR_W),
    .HAND   (HAND)
  ) u_probe_gen (
    .pos_row  (pos_row_nxt),
    .pos_col  (pos_col_nxt),
    .heading  (heading_nxt),
    .try_idx  (try_nxt),
    .cand_row (cand_row),
    .cand_col (cand_col),
    .cand_dir (cand_dir)
  );

  // Walk control: state, position, heading, try index and status flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt   = state;
    pos_row_nxt = pos_row;
    pos_col_nxt = pos_col;
    heading_nxt = heading;
    try_nxt     = try_idx;
    busy_nxt    = busy;
    done_nxt    = done;
    fail_nxt    = fail;
    step_inc    = step_count + STEP_W'(1);
    step_nxt    = step_count;

    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_nxt   = INIT;
          pos_row_nxt = starting_row;
          pos_col_nxt = starting_col;
          heading_nxt = EAST;
          try_nxt     = 2'd0;
          step_nxt    = '0;
          busy_nxt    = 1'b1;
          done_nxt    = 1'b0;
          fail_nxt    = 1'b0;
        end
      end
      INIT: begin
        if (on_border(pos_row, pos_col)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt = PROBE;
        end
      end
      PROBE: state_nxt = EVAL;
      EVAL: begin
        if (!maze_in) begin
          state_nxt = MOVE;
        end else if (try_idx == 2'd3) begin
          state_nxt = FAIL;
          fail_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt = PROBE;
          try_nxt   = try_idx + 2'd1;
        end
      end
      MOVE: begin
        // row/col still hold the accepted candidate from the last probe.
        pos_row_nxt = row;
        pos_col_nxt = col;
        heading_nxt = cand_dir_q;
        try_nxt     = 2'd0;
        step_nxt    = step_inc;
        if (on_border(row, col)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else if (step_inc == MAX_STEPS) begin
          state_nxt = FAIL;
          fail_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt = PROBE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory interface: address, read strobe and visit-mark strobe for the next cycle.
  always_comb begin
    row_nxt        = row;
    col_nxt        = col;
    oe_nxt         = 1'b0;
    we_nxt         = 1'b0;
    cand_dir_q_nxt = cand_dir_q;
    if (state_nxt == PROBE) begin
      row_nxt        = cand_row;
      col_nxt        = cand_col;
      oe_nxt         = 1'b1;
      cand_dir_q_nxt = cand_dir;
    end else if (state_nxt == INIT) begin
      row_nxt = starting_row;
      col_nxt = starting_col;
      we_nxt  = 1'b1;
    end else if (state_nxt == MOVE) begin
      we_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos_row    <= '0;
      pos_col    <= '0;
      heading    <= EAST;
      cand_dir_q <= EAST;
      try_idx    <= 2'd0;
      row        <= '0;
      col        <= '0;
      maze_oe    <= 1'b0;
      maze_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      step_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      pos_row    <= pos_row_nxt;
      pos_col    <= pos_col_nxt;
      heading    <= heading_nxt;
      cand_dir_q <= cand_dir_q_nxt;
      try_idx    <= try_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
      maze_oe    <= oe_nxt;
      maze_we    <= we_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      fail       <= fail_nxt;
      step_count <= step_nxt;
    end
  end

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker: an 8x8 maze memory model, an algorithmic
// golden walker feeding a scoreboard queue, and one DUT per hand rule.
module tb_maze_walker;

  localparam int              AW    = 3;
  localparam int              SW    = 16;
  localparam logic [SW-1:0]   MAXS  = 16'd10;
  localparam int              LIMIT = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_s [2];
  logic [AW-1:0] sr_s    [2];
  logic [AW-1:0] sc_s    [2];
  logic          min_s   [2];
  logic [AW-1:0] row_s   [2];
  logic [AW-1:0] col_s   [2];
  logic          oe_s    [2];
  logic          we_s    [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic          fail_s  [2];
  logic [SW-1:0] step_s  [2];

  maze_walker #(.ADDR_W(AW), .HAND(1'b0), .STEP_W(SW), .MAX_STEPS(MAXS)) u_right (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_s[0]),
    .starting_row (sr_s[0]),
    .starting_col (sc_s[0]),
    .maze_in      (min_s[0]),
    .row          (row_s[0]),
    .col          (col_s[0]),
    .maze_oe      (oe_s[0]),
    .maze_we      (we_s[0]),
    .busy         (busy_s[0]),
    .done         (done_s[0]),
    .fail         (fail_s[0]),
    .step_count   (step_s[0])
  );

  maze_walker #(.ADDR_W(AW), .HAND(1'b1), .STEP_W(SW), .MAX_STEPS(MAXS)) u_left (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_s[1]),
    .starting_row (sr_s[1]),
    .starting_col (sc_s[1]),
    .maze_in      (min_s[1]),
    .row          (row_s[1]),
    .col          (col_s[1]),
    .maze_oe      (oe_s[1]),
    .maze_we      (we_s[1]),
    .busy         (busy_s[1]),
    .done         (done_s[1]),
    .fail         (fail_s[1]),
    .step_count   (step_s[1])
  );

  // Maze memory: 1 = wall. Read data appears the cycle after the strobe.
  logic       walls [8][8];
  int         oe_cnt [2];
  int         we_cnt [2];
  logic [5:0] last_we [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (oe_s[k]) begin
        min_s[k]  <= walls[row_s[k]][col_s[k]];
        oe_cnt[k] <= oe_cnt[k] + 1;
      end
      if (we_s[k]) begin
        we_cnt[k]  <= we_cnt[k] + 1;
        last_we[k] <= {row_s[k], col_s[k]};
      end
    end
  end

  typedef struct {
    int done;
    int fail;
    int steps;
    int row;
    int col;
    int cycles;
    int probes;
    int wes;
    int we_addr;
  } res_t;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit border(int r, int c);
    return (r == 0) || (c == 0) || (r == 7) || (c == 7);
  endfunction

  task automatic fill_walls();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        walls[r][c] = 1'b1;
  endtask

  // Golden walker: follows the hand rule cell by cell and tallies the cycle cost.
  task automatic model(input int sr, input int sc, input int hand, output res_t e);
    int r, c, h, d, nr, nc;
    bit moved;
    int dr[4]    = '{0, -1, 0, 1};
    int dc[4]    = '{1, 0, -1, 0};
    int ord_r[4] = '{3, 0, 1, 2};
    int ord_l[4] = '{1, 0, 3, 2};
    e.done = 0; e.fail = 0; e.steps = 0; e.probes = 0;
    e.row = sr; e.col = sc; e.cycles = 1; e.wes = 1; e.we_addr = sr * 8 + sc;
    r = sr; c = sc; h = 0;
    if (border(r, c)) e.done = 1;
    while (e.done == 0 && e.fail == 0) begin
      moved = 1'b0;
      for (int t = 0; t < 4; t++) begin
        if (!moved) begin
          d  = (h + ((hand != 0) ? ord_l[t] : ord_r[t])) % 4;
          nr = (r + dr[d]) & 7;
          nc = (c + dc[d]) & 7;
          e.probes = e.probes + 1;
          e.cycles = e.cycles + 2;
          e.row = nr;
          e.col = nc;
          if (walls[nr][nc] == 1'b0) begin
            moved = 1'b1;
            r = nr; c = nc; h = d;
          end
        end
      end
      if (!moved) begin
        e.fail = 1;
      end else begin
        e.steps   = e.steps + 1;
        e.cycles  = e.cycles + 1;
        e.wes     = e.wes + 1;
        e.we_addr = r * 8 + c;
        if (border(r, c)) e.done = 1;
        else if (e.steps == int'(MAXS)) e.fail = 1;
      end
    end
  endtask

  task automatic walk(input int k, input string tag, input int sr, input int sc, output res_t g);
    res_t e;
    int   cyc;
    int   oe0, we0;
    model(sr, sc, k, e);
    exp_q.push_back(e);
    @(negedge clk);
    oe0 = oe_cnt[k];
    we0 = we_cnt[k];
    start_s[k] = 1'b1;
    sr_s[k]    = AW'(sr);
    sc_s[k]    = AW'(sc);
    @(posedge clk);
    #1;
    start_s[k] = 1'b0;
    check({tag, ".busy"}, busy_s[k], 1);
    cyc = 0;
    while (!(done_s[k] || fail_s[k]) && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".in_time"}, cyc < LIMIT, 1);
    g.done    = done_s[k];
    g.fail    = fail_s[k];
    g.steps   = step_s[k];
    g.row     = row_s[k];
    g.col     = col_s[k];
    g.cycles  = cyc;
    g.probes  = oe_cnt[k] - oe0;
    g.wes     = we_cnt[k] - we0;
    g.we_addr = last_we[k];
    e = exp_q.pop_front();
    check({tag, ".done"},    g.done,    e.done);
    check({tag, ".fail"},    g.fail,    e.fail);
    check({tag, ".steps"},   g.steps,   e.steps);
    check({tag, ".row"},     g.row,     e.row);
    check({tag, ".col"},     g.col,     e.col);
    check({tag, ".cycles"},  g.cycles,  e.cycles);
    check({tag, ".probes"},  g.probes,  e.probes);
    check({tag, ".marks"},   g.wes,     e.wes);
    check({tag, ".mark_at"}, g.we_addr, e.we_addr);
    check({tag, ".idle"},    busy_s[k], 0);
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    check({tag, ".row"},  row_s[k],  0);
    check({tag, ".col"},  col_s[k],  0);
    check({tag, ".oe"},   oe_s[k],   0);
    check({tag, ".we"},   we_s[k],   0);
    check({tag, ".busy"}, busy_s[k], 0);
    check({tag, ".done"}, done_s[k], 0);
    check({tag, ".fail"}, fail_s[k], 0);
    check({tag, ".step"}, step_s[k], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t g;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      sr_s[k]    = '0;
      sc_s[k]    = '0;
    end
    fill_walls();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs(0, "rst_r");
    check_reset_outputs(1, "rst_l");
    @(negedge clk);
    rst_n = 1'b1;

    // Straight corridor along row 3 to the east border.
    fill_walls();
    for (int c = 3; c < 8; c++) walls[3][c] = 1'b0;
    walk(0, "corridor", 3, 3, g);
    check("corridor.cycles21", g.cycles, 21);
    check("corridor.steps4",   g.steps,  4);
    check("corridor.end_col",  g.col,    7);
    check("corridor.marks5",   g.wes,    5);

    // Start already on the border: one mark, no probes.
    walk(0, "border", 0, 5, g);
    check("border.no_probe", g.probes, 0);
    check("border.cycles1",  g.cycles, 1);

    // Enclosed start: four probes, then fail.
    fill_walls();
    walk(0, "enclosed", 4, 4, g);
    check("enclosed.probes4", g.probes, 4);
    check("enclosed.fail",    g.fail,   1);

    // Closed ring with no exit: aborts at the step limit.
    fill_walls();
    for (int i = 2; i < 6; i++) begin
      walls[2][i] = 1'b0;
      walls[5][i] = 1'b0;
      walls[i][2] = 1'b0;
      walls[i][5] = 1'b0;
    end
    walk(0, "ring", 2, 2, g);
    check("ring.steps10", g.steps, 10);
    check("ring.no_done", g.done,  0);

    // Reset asserted in the middle of a corridor walk.
    fill_walls();
    for (int c = 3; c < 8; c++) walls[3][c] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b1;
    sr_s[0]    = 3'd3;
    sc_s[0]    = 3'd3;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst.busy_before", busy_s[0], 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Dead-end spur off a vertical corridor: the two hand rules exit at opposite ends.
    fill_walls();
    for (int r = 0; r < 8; r++) walls[r][2] = 1'b0;
    walls[4][3] = 1'b0;
    walls[4][4] = 1'b0;
    walk(0, "right_hand", 4, 4, g);
    check("right_hand.exit_row", g.row, 0);
    check("right_hand.exit_col", g.col, 2);
    walk(1, "left_hand", 4, 4, g);
    check("left_hand.exit_row", g.row, 7);
    check("left_hand.exit_col", g.col, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
